apb_rr_arbiter: RTL

- Shares one APB v2.0 master port between NumReq requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel and receives a one-cycle response pulse.
- The block runs the APB phase FSM (IDLE/SETUP/ACCESS), latches the winning request and returns PRDATA/PSLVERR to the winner.
- An optional PREADY timeout terminates a hung slave access with SLVERR.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_rr_arbiter_sel.sv | 35 +++
 rtl/apb_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB types: protection field, response codes and the APB phase state.
package apb_pkg;

    typedef logic [2:0] prot_t;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter_sel.sv
// Combinational round-robin picker: the first valid requester at or above the
// pointer wins, otherwise the first valid one below it.
module apb_rr_arbiter_sel #(
    parameter int NumReq = 4,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int j = 0; j < NumReq; j++) begin
            if (!any_o && valid_i[j] && (j >= int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
                any_o      = 1'b1;
            end
        end
        // wrap-around pass over the requesters below the pointer
        for (int j = 0; j < NumReq; j++) begin
            if (!any_o && valid_i[j] && (j < int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin sharing of one APB master port between NumReq valid/ready
// requesters, with an optional PREADY timeout that forces SLVERR completion.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0] req_strb_i,
    input  logic [NumReq*3-1:0]           req_prot_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_slverr_o,
    output logic [AddrWidth-1:0]          paddr_o,
    output prot_t                         pprot_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [DataWidth-1:0]          pwdata_o,
    output logic [DataWidth/8-1:0]        pstrb_o,
    input  logic                          pready_i,
    input  logic [DataWidth-1:0]          prdata_i,
    input  logic                          pslverr_i
);

    localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int StrbW = DataWidth / 8;
    localparam int CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    apb_state_e        state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   owner_q;
    logic [CntW-1:0]   cnt_q;
    logic [NumReq-1:0] grant;
    logic [IdxW-1:0]   win_idx;
    logic              any_valid;
    logic              timeout_hit;
    logic              complete;
    logic              arb;

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx);
        if (int'(idx) == NumReq - 1) return '0;
        return idx + 1'b1;
    endfunction

    apb_rr_arbiter_sel #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_sel (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_valid)
    );

    // pready in the expiry cycle wins over the timeout
    assign timeout_hit = (TimeoutCycles != 0) && (state_q == ACCESS) && !pready_i
                         && (cnt_q == CntLast);
    assign complete    = (state_q == ACCESS) && (pready_i || timeout_hit);
    assign arb         = (state_q == IDLE) || complete;
    assign req_ready_o = arb ? grant : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if ((TimeoutCycles != 0) && (state_q == ACCESS) && !pready_i && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pprot_o   <= '0;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            pstrb_o   <= '0;
        end else if (arb && any_valid) begin
            state_q   <= SETUP;
            ptr_q     <= next_ptr(win_idx);
            owner_q   <= win_idx;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= req_addr_i[win_idx*AddrWidth +: AddrWidth];
            pprot_o   <= req_prot_i[win_idx*3 +: 3];
            pwrite_o  <= req_write_i[win_idx];
            pwdata_o  <= req_wdata_i[win_idx*DataWidth +: DataWidth];
            pstrb_o   <= req_strb_i[win_idx*StrbW +: StrbW];
        end else if (state_q == SETUP) begin
            state_q   <= ACCESS;
            penable_o <= 1'b1;
        end else if (complete) begin
            // address/data keep their last values once the bus goes idle
            state_q   <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= RESP_OKAY;
        end else if (complete) begin
            rsp_valid_o          <= '0;
            rsp_valid_o[owner_q] <= 1'b1;
            rsp_rdata_o          <= (pwrite_o || timeout_hit) ? '0 : prdata_i;
            rsp_slverr_o         <= timeout_hit ? RESP_SLVERR : pslverr_i;
        end else begin
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= RESP_OKAY;
        end
    end

endmodule
